adder_bist: RTL and testbench
=============================

ADDER_BIST -- requirements
Module: adder_bist

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving the operand width of the adder under test.
REQ-002 The module SHALL have parameter SETTLE_CYCLES, default 1, range 1..15, giving the clock cycles each vector is held before sampling.
REQ-003 The module SHALL have port clk, input, 1, the single rising-edge clock.
REQ-004 The module SHALL have port rst, input, 1, the asynchronous active-high reset.
REQ-005 The module SHALL have port start, input, 1, a request to begin a test run.
REQ-006 The module SHALL have port a, output, WIDTH, operand A driven to the adder under test.
REQ-007 The module SHALL have port b, output, WIDTH, operand B driven to the adder under test.
REQ-008 The module SHALL have port cin, output, 1, the carry-in driven to the adder under test.
REQ-009 The module SHALL have port sum, input, WIDTH, the sum returned by the adder under test.
REQ-010 The module SHALL have port cout, input, 1, the carry-out returned by the adder under test.
REQ-011 The module SHALL have port busy, output, 1, high while a run is in progress.
REQ-012 The module SHALL have port done, output, 1, high once a run has completed, until the next start or reset.
REQ-013 The module SHALL have port pass, output, 1, qualified by done; 1 means zero mismatches.
REQ-014 The module SHALL have port err_count, output, 16, the saturating mismatch count.

Function
REQ-015 Vector register vec SHALL be 2*WIDTH+1 bits, decoded as {a,b,cin}, with a in the MSBs; outputs a, b and cin SHALL be driven directly from vec.
REQ-016 The FSM SHALL have four states: IDLE, APPLY, CHECK and DONE.
REQ-017 In IDLE or DONE, start=1 at a clock edge SHALL set vec=0, err_count=0 and settle counter=0, then move to APPLY.
REQ-018 In APPLY, the settle counter SHALL increment each cycle, and the FSM SHALL move to CHECK once SETTLE_CYCLES cycles have been spent in APPLY.
REQ-019 In CHECK, {cout,sum} SHALL be compared with the (WIDTH+1)-bit value a+b+cin.
REQ-020 On a mismatch, err_count SHALL increment by 1 and SHALL saturate at 16'hFFFF.
REQ-021 From CHECK, if vec is all ones the FSM SHALL go to DONE; otherwise vec SHALL increment, the settle counter SHALL clear, and the FSM SHALL return to APPLY.
REQ-022 Each vector SHALL take SETTLE_CYCLES+1 cycles, and done SHALL rise exactly 2^(2*WIDTH+1)*(SETTLE_CYCLES+1) cycles after the start edge (1024 cycles at the defaults).
REQ-023 busy SHALL be 1 exactly in APPLY and CHECK; done SHALL be 1 exactly in DONE.
REQ-024 pass SHALL equal (err_count==0) while in DONE and SHALL be 0 otherwise.
REQ-025 start SHALL be ignored while busy=1.
REQ-026 start=1 in DONE SHALL restart the run, with done dropping on the same edge that enters APPLY.
REQ-027 The block SHALL sample sum and cout only in CHECK; their values in other states SHALL have no effect.
REQ-028 In DONE, a, b and cin SHALL hold the final vector (all ones).

Reset
REQ-029 rst=1 SHALL immediately force state=IDLE, vec=0, settle counter=0, err_count=0, busy=0, done=0 and pass=0, regardless of the current state.
REQ-030 Reset asserted mid-run SHALL abort the run with no done pulse; a new start SHALL be required after rst falls.
REQ-031 If FAIL_CAPTURE is compiled in, reset SHALL also clear first_fail_vec, first_fail_got and first_fail_valid to 0.

Configuration
REQ-032 Macro ADDER_BIST_FAIL_CAPTURE_EN defined SHALL add three outputs: first_fail_valid (1 bit), first_fail_vec (2*WIDTH+1 bits) and first_fail_got (WIDTH+1 bits).
REQ-033 With the macro defined, the first mismatch of a run SHALL load vec and {cout,sum} into those outputs and set first_fail_valid; later mismatches SHALL NOT overwrite them, and start SHALL clear them.
REQ-034 With the macro undefined, those ports and registers SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-035 Scenario 1: a correct 4-bit adder is connected and start is pulsed -> done rises 1024 cycles later, with err_count=0 and pass=1.
REQ-036 Scenario 2: sum[0] is forced to 0 -> done rises with err_count=256 and pass=0; with the macro defined, first_fail_vec=9'h001 and first_fail_got=5'b00000.
REQ-037 Scenario 3: cout is forced to 0 -> err_count=256 and pass=0.
REQ-038 Scenario 4: rst is asserted for one cycle at cycle 300 of a run -> busy=0, done=0 and err_count=0 immediately; a later start completes normally with pass=1.
REQ-039 Scenario 5: start is pulsed at cycle 10 of a run -> it is ignored, and done still rises at cycle 1024 after the original start.
REQ-040 Scenario 6: start is pulsed in DONE after a failing run -> done drops the next cycle, err_count=0, and the new run completes with pass=1 against a correct adder.

Source files
------------

// File: rtl/adder_bist.sv
// adder_bist: exhaustive built-in self test for a combinational adder.
//   Walks every {a,b,cin} combination, holds each vector for SETTLE_CYCLES
//   clocks, then compares {cout,sum} against a+b+cin and counts mismatches.
// Ports:
//   clk, rst      - rising-edge clock, asynchronous active-high reset
//   start         - begin a run (honoured in IDLE or DONE only)
//   a, b, cin     - operands driven to the adder under test
//   sum, cout     - result returned by the adder under test
//   busy, done    - run in progress / run finished
//   pass          - qualified by done, 1 = no mismatches
//   err_count     - saturating mismatch count
// Optional: define ADDER_BIST_FAIL_CAPTURE_EN to add first_fail_valid,
//   first_fail_vec and first_fail_got (first mismatching vector and result).
module adder_bist #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             cin,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
  output logic             first_fail_valid,
  output logic [2*WIDTH:0] first_fail_vec,
  output logic [WIDTH:0]   first_fail_got,
`endif
  output logic [15:0]      err_count
);

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

  // Last settle count value before moving to CHECK.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t           state, nxt;
  logic [2*WIDTH:0] vec;
  logic [3:0]       cnt;
  logic [WIDTH:0]   expect_sum;
  logic             mismatch;
  logic             vec_last;

  assign {a, b, cin} = vec;
  assign expect_sum  = (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(cin);
  assign mismatch    = ({cout, sum} != expect_sum);
  assign vec_last    = &vec;

  assign busy = (state == APPLY) || (state == CHECK);
  assign done = (state == DONE);
  assign pass = done && (err_count == 16'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: if (start) nxt = APPLY;
      APPLY:      if (cnt == SETTLE_LAST) nxt = CHECK;
      CHECK:      nxt = vec_last ? DONE : APPLY;
      default:    nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec       <= '0;
      cnt       <= '0;
      err_count <= '0;
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
      first_fail_got   <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            vec       <= '0;
            cnt       <= '0;
            err_count <= '0;
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            first_fail_got   <= '0;
`endif
          end
        end
        APPLY: cnt <= cnt + 4'd1;
        CHECK: begin
          // sum/cout are only looked at here; outside CHECK they are ignored.
          if (mismatch) begin
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_vec   <= vec;
              first_fail_got   <= {cout, sum};
            end
`endif
          end
          // On the final vector vec is left at all ones for DONE.
          if (!vec_last) begin
            vec <= vec + 1'b1;
            cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_bist.sv
module tb_adder_bist;
  localparam int W    = 4;
  localparam int S    = 1;
  localparam int NVEC = 1 << (2*W+1);
  localparam int RUN  = NVEC * (S+1);

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] a, b, sum;
  logic         cin, cout, busy, done, pass;
  logic [15:0]  err_count;
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
  logic         ff_valid;
  logic [2*W:0] ff_vec;
  logic [W:0]   ff_got;
`endif

  // Fault model of the adder under test: 0 good, 1 sum[0]=0, 2 cout=0,
  // 3 result bit fbit stuck at fval.
  int mode = 0, fbit = 0, fval = 0;
  int vectors = 0, miscompares = 0;
  int cyc = 0;

  typedef struct {
    int start_cyc;
    int err;
    int ffvec;
    int ffgot;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;
  bit   prev_done = 1'b0;

  adder_bist #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
    .busy(busy), .done(done), .pass(pass),
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
    .first_fail_valid(ff_valid), .first_fail_vec(ff_vec), .first_fail_got(ff_got),
`endif
    .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W:0] model(int md, int fb, int fv,
                                       logic [W-1:0] x, logic [W-1:0] y, logic c);
    logic [W:0] r;
    r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    case (md)
      1: r[0] = 1'b0;
      2: r[W] = 1'b0;
      3: r[fb] = fv[0];
      default: ;
    endcase
    return r;
  endfunction

  assign {cout, sum} = model(mode, fbit, fval, a, b, cin);

  task automatic chk(string name, int got, int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference: enumerate all vectors with plain arithmetic.
  task automatic predict(output exp_t e);
    int n = 0;
    bit first = 1'b1;
    e.ffvec = 0;
    e.ffgot = 0;
    for (int v = 0; v < NVEC; v++) begin
      int x, y, c, good, got;
      x = v >> (W+1);
      y = (v >> 1) & ((1 << W) - 1);
      c = v & 1;
      good = x + y + c;
      got  = int'(model(mode, fbit, fval, W'(x), W'(y), c[0]));
      if (got != good) begin
        n++;
        if (first) begin
          e.ffvec = v;
          e.ffgot = got;
          first = 1'b0;
        end
      end
    end
    e.err = (n > 65535) ? 65535 : n;
  endtask

  task automatic start_run(bit push);
    exp_t e;
    predict(e);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    e.start_cyc = cyc;
    chk("start_busy", int'(busy), 1);
    chk("start_done_low", int'(done), 0);
    chk("start_err_clr", int'(err_count), 0);
    if (push) q.push_back(e);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < RUN + 50 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  // Monitor: pops an expectation on each rising done.
  always @(negedge clk) begin
    if (done && !prev_done) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        mon_e = q.pop_front();
        chk("done_latency", cyc - mon_e.start_cyc, RUN);
        chk("err_count", int'(err_count), mon_e.err);
        chk("pass", int'(pass), int'(mon_e.err == 0));
        chk("busy_in_done", int'(busy), 0);
        chk("final_vec", int'({a, b, cin}), NVEC - 1);
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
        chk("ff_valid", int'(ff_valid), int'(mon_e.err != 0));
        chk("ff_vec", int'(ff_vec), mon_e.ffvec);
        chk("ff_got", int'(ff_got), mon_e.ffgot);
`endif
      end
    end
    prev_done = done;
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_err", int'(err_count), 0);
    chk("rst_vec", int'({a, b, cin}), 0);
    rst = 1'b0;
    repeat ($urandom_range(1, 5)) @(negedge clk);

    // Good adder.
    mode = 0;
    start_run(1);
    wait_done();

    // sum[0] stuck at 0, then restart from DONE.
    mode = 1;
    start_run(1);
    wait_done();

    // cout stuck at 0.
    mode = 2;
    start_run(1);
    wait_done();

    // Restart after a failing run, with a start pulse mid-run that must be ignored.
    mode = 0;
    start_run(1);
    repeat (9) @(posedge clk);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done();

    // Abort mid-run: no done may follow.
    mode = 1;
    start_run(0);
    repeat (298) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_err", int'(err_count), 0);
    chk("abort_pass", int'(pass), 0);
    @(negedge clk) rst = 1'b0;
    repeat (RUN + 20) @(negedge clk);
    chk("abort_no_done", int'(done), 0);
    mode = 0;
    start_run(1);
    wait_done();

    // Random stuck-at faults on the result bits.
    for (int r = 0; r < 3; r++) begin
      mode = 3;
      fbit = int'($urandom_range(0, W));
      fval = int'($urandom_range(0, 1));
      repeat ($urandom_range(0, 4)) @(negedge clk);
      start_run(1);
      wait_done();
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
